// File: rtl/inv_sqrt_iter.sv
// Handshaked FP32 inverse square root: magic-constant seed followed by
// NR_ITERS Newton-Raphson refinements on one shared multiplier and subtractor.
module inv_sqrt_iter #(
    parameter int unsigned NR_ITERS = 2,
    parameter logic [31:0] MAGIC    = 32'h5f3759df,
    parameter int unsigned TAG_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic [1:0]       out_flags
);

    localparam int unsigned CNT_W = 2;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SEED = 3'd1;
    localparam logic [2:0] S_SQ   = 3'd2;
    localparam logic [2:0] S_MULX = 3'd3;
    localparam logic [2:0] S_SUB  = 3'd4;
    localparam logic [2:0] S_MULY = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    // Positive-operand FP32 multiply: truncated mantissa, flush to +0, saturate to +inf.
    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        logic [9:0]  es;
        logic [22:0] m;
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return 32'd0;
        p  = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        es = 10'({2'b00, a[30:23]}) + 10'({2'b00, b[30:23]}) + 10'({9'd0, p[47]});
        m  = p[47] ? p[46:24] : p[45:23];
        if (es <= 10'd127) return 32'd0;
        if (es >= 10'd382) return 32'h7f80_0000;
        return {a[31] ^ b[31], 8'(es - 10'd127), m};
    endfunction

    // 1.5 - h on a 2.30 fixed-point grid, renormalised to FP32 with truncation.
    function automatic logic [31:0] fp_sub15(input logic [30:0] h);
        logic [31:0] fx;
        logic [31:0] d;
        logic [31:0] norm;
        logic [7:0]  sh;
        logic [4:0]  pos;
        if (h[30:23] > 8'd127 || (h[30:23] == 8'd127 && h[22])) return 32'd0;
        sh = 8'd127 - h[30:23];
        if (h[30:23] == 8'd0 || sh >= 8'd31) fx = 32'd0;
        else fx = (32'({1'b1, h[22:0]}) << 7) >> sh;
        d   = 32'h6000_0000 - fx;
        pos = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (d[i]) pos = 5'(i);
        end
        norm = d << (5'd31 - pos);
        return {1'b0, 8'd97 + 8'({3'd0, pos}), norm[30:8]};
    endfunction

    logic [2:0]       state_q, state_d;
    logic [31:0]      x_q, x_d, y_q, y_d, t_q, t_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d;
    logic [31:0]      out_data_q, out_data_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic [1:0]       out_flags_q, out_flags_d;

    logic [31:0] mul_a, mul_b, mul_p, half_p;
    logic        spec_hit;
    logic [31:0] spec_data;
    logic [1:0]  spec_flags;

    // Shared multiplier operand steering
    always_comb begin
        mul_a  = (state_q == S_MULX) ? x_q : y_q;
        mul_b  = (state_q == S_SQ) ? y_q : t_q;
        mul_p  = fp_mul(mul_a, mul_b);
        half_p = (mul_p[30:23] <= 8'd1) ? 32'd0
               : (mul_p[30:23] == 8'hff) ? mul_p
               : {mul_p[31], mul_p[30:23] - 8'd1, mul_p[22:0]};
    end

    // Special-input classification; subnormals count as signed zero
    always_comb begin
        spec_hit   = 1'b1;
        spec_data  = 32'd0;
        spec_flags = 2'b00;
        if (in_data[30:23] == 8'd0) begin
            spec_data  = {in_data[31], 8'hff, 23'd0};
            spec_flags = 2'b01;
        end else if ((in_data[30:23] == 8'hff && in_data[22:0] != 23'd0) || in_data[31]) begin
            spec_data  = 32'h7fc0_0000;
            spec_flags = 2'b10;
        end else if (in_data[30:23] != 8'hff) begin
            spec_hit = 1'b0;
        end
    end

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        t_d         = t_q;
        cnt_d       = cnt_q;
        tag_d       = tag_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_tag_d   = out_tag_q;
        out_flags_d = out_flags_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    x_d        = in_data;
                    tag_d      = in_tag;
                    cnt_d      = CNT_W'(NR_ITERS);
                    in_ready_d = 1'b0;
                    if (spec_hit) begin
                        state_d     = S_DONE;
                        out_valid_d = 1'b1;
                        out_data_d  = spec_data;
                        out_flags_d = spec_flags;
                        out_tag_d   = in_tag;
                    end else begin
                        state_d = S_SEED;
                    end
                end
            end
            S_SEED: begin
                y_d = MAGIC - (x_q >> 1);
                if (NR_ITERS == 0) begin
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                    out_data_d  = y_d;
                    out_flags_d = 2'b00;
                    out_tag_d   = tag_q;
                end else begin
                    state_d = S_SQ;
                end
            end
            S_SQ: begin
                t_d     = mul_p;
                state_d = S_MULX;
            end
            S_MULX: begin
                t_d     = half_p;
                state_d = S_SUB;
            end
            S_SUB: begin
                t_d     = fp_sub15(t_q[30:0]);
                state_d = S_MULY;
            end
            S_MULY: begin
                y_d   = mul_p;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                    out_data_d  = mul_p;
                    out_flags_d = 2'b00;
                    out_tag_d   = tag_q;
                end else begin
                    state_d = S_SQ;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = S_IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            x_q         <= 32'd0;
            y_q         <= 32'd0;
            t_q         <= 32'd0;
            cnt_q       <= '0;
            tag_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= 32'd0;
            out_tag_q   <= '0;
            out_flags_q <= 2'b00;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            t_q         <= t_d;
            cnt_q       <= cnt_d;
            tag_q       <= tag_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_tag_q   <= out_tag_d;
            out_flags_q <= out_flags_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;
    assign out_flags = out_flags_q;

endmodule

// File: tb/tb_inv_sqrt_iter.sv
// Directed bench for inv_sqrt_iter: default 2-iteration instance plus a seed-only instance.
module tb_inv_sqrt_iter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
    logic [31:0] in_data = 32'd0, out_data;
    logic [3:0]  in_tag = 4'd0, out_tag;
    logic [1:0]  out_flags;

    logic        in_valid_z = 1'b0, in_ready_z, out_valid_z, out_ready_z = 1'b1;
    logic [31:0] in_data_z = 32'd0, out_data_z;
    logic [3:0]  in_tag_z = 4'd0, out_tag_z;
    logic [1:0]  out_flags_z;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    inv_sqrt_iter dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .out_flags(out_flags)
    );

    inv_sqrt_iter #(.NR_ITERS(0)) dut0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_z), .in_ready(in_ready_z), .in_data(in_data_z), .in_tag(in_tag_z),
        .out_valid(out_valid_z), .out_ready(out_ready_z), .out_data(out_data_z),
        .out_tag(out_tag_z), .out_flags(out_flags_z)
    );

    function automatic real f2r(input logic [31:0] b);
        real m;
        int  e;
        int  mi;
        mi = int'({9'd0, b[22:0]});
        m  = 1.0 + $itor(mi) / 8388608.0;
        e  = int'({24'd0, b[30:23]}) - 127;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return b[31] ? -m : m;
    endfunction

    function automatic real relerr(input logic [31:0] got, input real want);
        real r;
        r = (f2r(got) - want) / want;
        return (r < 0.0) ? -r : r;
    endfunction

    // Drive one word into the default instance; returns just after the accepting edge
    task automatic send(input logic [31:0] d, input logic [3:0] t);
        in_data  = d;
        in_tag   = t;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Cycles from the accepting edge until out_valid is seen; 999 on timeout
    task automatic wait_valid(output int lat, output logic saw_ready);
        lat = 1;
        saw_ready = in_ready;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            if (!out_valid) saw_ready = saw_ready | in_ready;
        end
        if (!out_valid) lat = 999;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        vectors++;
        if (out_data !== 32'd0) begin miscompares++; $display("FAIL reset_out_data got=%h want=00000000", out_data); end
        vectors++;
        if (out_tag !== 4'd0 || out_flags !== 2'b00) begin
            miscompares++; $display("FAIL reset_tag_flags got=%h/%b want=0/00", out_tag, out_flags);
        end
        vectors++;
        if (out_valid_z !== 1'b0) begin miscompares++; $display("FAIL reset_nr0_valid got=%b want=0", out_valid_z); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_default;
        int   lat;
        logic sr;
        out_ready = 1'b1;
        send(32'h3f000000, 4'd3);
        wait_valid(lat, sr);
        vectors++;
        if (lat !== 10) begin miscompares++; $display("FAIL default_latency got=%0d want=10", lat); end
        vectors++;
        if (relerr(out_data, 1.41421356) > 1e-5) begin
            miscompares++; $display("FAIL default_value got=%h (%f) want=1.414214", out_data, f2r(out_data));
        end
        vectors++;
        if (out_tag !== 4'd3 || out_flags !== 2'b00) begin
            miscompares++; $display("FAIL default_tag_flags got=%h/%b want=3/00", out_tag, out_flags);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++; $display("FAIL default_handshake got valid=%b ready=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] din [3] = '{32'h3efff2e5, 32'h3e75c28f, 32'h40800000};
        real         want[3] = '{1.41435498, 2.04124145, 0.5};
        int          lat;
        logic        sr;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(din[i], 4'(i));
            wait_valid(lat, sr);
            vectors++;
            if (sr !== 1'b0 || lat !== 10) begin
                miscompares++; $display("FAIL seq%0d_ready_latency got ready_seen=%b lat=%0d want 0/10", i, sr, lat);
            end
            vectors++;
            if (relerr(out_data, want[i]) > 1e-5) begin
                miscompares++; $display("FAIL seq%0d_value got=%h (%f) want=%f", i, out_data, f2r(out_data), want[i]);
            end
            vectors++;
            if (out_tag !== 4'(i)) begin miscompares++; $display("FAIL seq%0d_tag got=%0d want=%0d", i, out_tag, i); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_nr0;
        int lat;
        in_data_z  = 32'h3f000000;
        in_tag_z   = 4'd7;
        in_valid_z = 1'b1;
        @(posedge clk);
        #1;
        in_valid_z = 1'b0;
        lat = 1;
        while (!out_valid_z && lat < 50) begin @(posedge clk); #1; lat++; end
        vectors++;
        if (lat !== 2) begin miscompares++; $display("FAIL nr0_latency got=%0d want=2", lat); end
        vectors++;
        if (out_data_z !== 32'h3fb759df || out_tag_z !== 4'd7) begin
            miscompares++; $display("FAIL nr0_value got=%h/%h want=3fb759df/7", out_data_z, out_tag_z);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_special;
        logic [31:0] din [5] = '{32'h00000000, 32'h80000000, 32'hbf800000, 32'h7f800000, 32'h7fc00001};
        logic [31:0] dout[5] = '{32'h7f800000, 32'hff800000, 32'h7fc00000, 32'h00000000, 32'h7fc00000};
        logic [1:0]  fl  [5] = '{2'b01, 2'b01, 2'b10, 2'b00, 2'b10};
        int          lat;
        logic        sr;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(din[i], 4'(i + 8));
            wait_valid(lat, sr);
            vectors++;
            if (lat !== 1) begin miscompares++; $display("FAIL special%0d_latency got=%0d want=1", i, lat); end
            vectors++;
            if (out_data !== dout[i] || out_flags !== fl[i] || out_tag !== 4'(i + 8)) begin
                miscompares++;
                $display("FAIL special%0d_result got=%h/%b/%h want=%h/%b/%h", i, out_data, out_flags, out_tag,
                         dout[i], fl[i], 4'(i + 8));
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_backpressure;
        int          lat;
        logic        sr;
        logic        bad;
        logic [31:0] d;
        logic [3:0]  t;
        logic [1:0]  f;
        out_ready = 1'b0;
        send(32'h40800000, 4'd9);
        wait_valid(lat, sr);
        d = out_data; t = out_tag; f = out_flags;
        vectors++;
        if (relerr(d, 0.5) > 1e-5 || t !== 4'd9) begin
            miscompares++; $display("FAIL bp_value got=%h/%h want=~0.5/9", d, t);
        end
        bad = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (!out_valid || in_ready || out_data !== d || out_tag !== t || out_flags !== f) bad = 1'b1;
        end
        vectors++;
        if (bad !== 1'b0) begin miscompares++; $display("FAIL bp_hold got=unstable want=stable"); end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== d) begin
            miscompares++; $display("FAIL bp_release got valid=%b ready=%b data=%h want 0/1/%h", out_valid, in_ready, out_data, d);
        end
    endtask

    task automatic test_mid_reset;
        int   lat;
        logic sr;
        logic seen;
        out_ready = 1'b1;
        send(32'h40800000, 4'd5);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++; $display("FAIL midreset_state got valid=%b ready=%b want 0/1", out_valid, in_ready);
        end
        rst = 1'b1;
        seen = 1'b0;
        repeat (12) begin @(posedge clk); #1; seen = seen | out_valid; end
        vectors++;
        if (seen !== 1'b0) begin miscompares++; $display("FAIL midreset_stale got=1 want=0"); end
        send(32'h40800000, 4'd6);
        wait_valid(lat, sr);
        vectors++;
        if (lat !== 10 || relerr(out_data, 0.5) > 1e-5 || out_tag !== 4'd6) begin
            miscompares++; $display("FAIL midreset_new got lat=%0d data=%h tag=%h want 10/~0.5/6", lat, out_data, out_tag);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_default();
        test_back_to_back();
        test_nr0();
        test_special();
        test_backpressure();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
